ptp_tstamp_arbiter: RTL and testbench
=====================================

PTP_TSTAMP_ARBITER -- requirements
Module: ptp_tstamp_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, the number of per-MAC timestamp sources (range 2..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, the entries per port queue (power of two, 2..16).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of each drop counter.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ts_valid  input  NUM_PORTS  per-port one-cycle strobe, timestamp present.
REQ-007 ts_hi  input  NUM_PORTS*32  per-port upper 32 timestamp bits; port p occupies [32p+31:32p].
REQ-008 ts_lo  input  NUM_PORTS*32  per-port lower 32 timestamp bits, same packing.
REQ-009 out_valid  output  1  output entry valid.
REQ-010 out_ready  input  1  consumer accepts entry.
REQ-011 out_port  output  3  source port index of output entry.
REQ-012 out_time_hi / out_time_lo  output  32 / 32  timestamp of output entry.
REQ-013 drop  output  NUM_PORTS  one-cycle pulse per port when a timestamp is discarded.
REQ-014 drop_cnt  output  NUM_PORTS*CNT_WIDTH  per-port saturating drop counts; present only with PTP_TSTAMP_DROP_CNT_EN.

Function
REQ-015 Each port SHALL own a FIFO_DEPTH-entry FIFO of {ts_hi, ts_lo}; a ts_valid sample is written on that clock edge.
REQ-016 A write to a full FIFO SHALL be accepted only if the same FIFO is popped in that cycle; otherwise the sample is discarded, FIFO contents are unchanged, and drop[p] is high for the following cycle.
REQ-017 The output stage SHALL be a single register; it loads when empty or when out_valid && out_ready in the current cycle.
REQ-018 On load, the arbiter SHALL grant the first non-empty FIFO searching round-robin from (last_grant+1) mod NUM_PORTS, pop it, and update last_grant to the granted port.
REQ-019 Pointer wrap SHALL make port 0 follow port NUM_PORTS-1; a port never waits more than NUM_PORTS-1 grants to others.
REQ-020 Latency: ts_valid in cycle N with empty FIFO and empty output register SHALL give out_valid in cycle N+2.
REQ-021 While out_valid && !out_ready, out_port, out_time_hi and out_time_lo SHALL remain stable.
REQ-022 Back-to-back throughput SHALL be one entry per cycle while out_ready is held high and any FIFO is non-empty.
REQ-023 When no FIFO is non-empty at load time, out_valid SHALL go low and data outputs SHALL hold their last values.
REQ-024 Simultaneous ts_valid on all ports SHALL be accepted into all non-full FIFOs in the same cycle.

Reset
REQ-025 Reset SHALL empty all FIFOs and clear out_valid, out_port, out_time_hi, out_time_lo, drop and drop_cnt to 0.
REQ-026 Reset SHALL set last_grant to NUM_PORTS-1 so that port 0 has first priority.
REQ-027 Reset asserted mid-transfer SHALL discard all queued and presented entries with no drop pulse.

Configuration
REQ-028 With macro PTP_TSTAMP_DROP_CNT_EN defined, each port SHALL keep a CNT_WIDTH counter that increments on every drop pulse and saturates at all-ones.
REQ-029 Without PTP_TSTAMP_DROP_CNT_EN, the drop_cnt port and its counters SHALL be absent; drop pulses remain.

Structure
REQ-030 Package ptp_tstamp_pkg SHALL hold TS_WIDTH=64, the max port count of 8, and the timestamp entry struct {hi, lo}.
REQ-031 The per-port queue SHALL be sub-module ptp_tstamp_fifo, instantiated NUM_PORTS times.
REQ-032 Round-robin selection and the output register SHALL reside in the top module.

Verification
REQ-033 Scenario 1: ts_valid[2] with hi=0x1, lo=0x2 in cycle 10 and out_ready=1 -> out_valid in cycle 12 with out_port=2 and time 0x1/0x2.
REQ-034 Scenario 2: all 4 ports strobe together after reset with out_ready=1 -> outputs in port order 0,1,2,3 on consecutive cycles.
REQ-035 Scenario 3: out_ready=0 and 5 strobes on port 1 -> fifth strobe dropped, drop[1] pulses once, drop_cnt[1]=1 with the macro defined.
REQ-036 Scenario 4: out_ready toggling 1,0,1 while out_valid is high -> data held stable during the 0 cycle, and no entry is lost or duplicated.
REQ-037 Scenario 5: ports 0 and 3 continuously backlogged -> grants alternate 0,3,0,3.
REQ-038 Scenario 6: reset pulsed while 3 entries are queued -> out_valid=0 next cycle, and the next grant goes to port 0.

Source files
------------

// File: rtl/ptp_tstamp_pkg.sv
// Shared types and limits for the PTP timestamp arbiter.
// Optional drop counters are enabled by defining PTP_TSTAMP_DROP_CNT_EN.
package ptp_tstamp_pkg;
  localparam int TS_WIDTH   = 64;
  localparam int MAX_PORTS  = 8;
  localparam int PORT_IDX_W = $clog2(MAX_PORTS);

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } ts_entry_t;
endpackage

// File: rtl/ptp_tstamp_fifo.sv
// Per-port timestamp queue with registered drop strobe.
// A write into a full queue is only accepted when the queue is popped in the same cycle.
module ptp_tstamp_fifo
  import ptp_tstamp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [TS_WIDTH-1:0] wr_data_i,
  input  logic                rd_en_i,
  output logic [TS_WIDTH-1:0] rd_data_o,
  output logic                empty_o,
  output logic                drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [TS_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                drop_q;
  logic                full, pop, wr_accept;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign pop       = rd_en_i && !empty_o;
  assign wr_accept = wr_en_i && (!full || pop);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign drop_o    = drop_q;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= wr_en_i && !wr_accept;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_accept, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ptp_tstamp_arbiter.sv
// Round-robin merge of per-MAC timestamp queues into one registered output.
// Define PTP_TSTAMP_DROP_CNT_EN to add saturating per-port drop counters (drop_cnt).
module ptp_tstamp_arbiter
  import ptp_tstamp_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            ts_valid,
  input  logic [NUM_PORTS*32-1:0]         ts_hi,
  input  logic [NUM_PORTS*32-1:0]         ts_lo,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PORT_IDX_W-1:0]           out_port,
  output logic [31:0]                     out_time_hi,
  output logic [31:0]                     out_time_lo,
`ifdef PTP_TSTAMP_DROP_CNT_EN
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  drop_cnt,
`endif
  output logic [NUM_PORTS-1:0]            drop
);
  logic [NUM_PORTS-1:0]  fifo_empty, pop;
  logic [TS_WIDTH-1:0]   fifo_rd [NUM_PORTS];

  logic                  out_valid_q, out_valid_d;
  logic [PORT_IDX_W-1:0] out_port_q, out_port_d;
  ts_entry_t             out_data_q, out_data_d;
  logic [PORT_IDX_W-1:0] last_grant_q, last_grant_d;
  logic                  load, found;
  int                    idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ptp_tstamp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (ts_valid[p]),
      .wr_data_i ({ts_hi[32*p +: 32], ts_lo[32*p +: 32]}),
      .rd_en_i   (pop[p]),
      .rd_data_o (fifo_rd[p]),
      .empty_o   (fifo_empty[p]),
      .drop_o    (drop[p])
    );
  end

  // Search starts one past the last grant, so every port is reached within NUM_PORTS grants.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_port_d   = out_port_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    pop          = '0;
    found        = 1'b0;
    idx          = 0;
    load         = !out_valid_q || out_ready;
    if (load) begin
      out_valid_d = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        idx = (int'(last_grant_q) + 1 + i) % NUM_PORTS;
        if (!found && !fifo_empty[idx]) begin
          found        = 1'b1;
          pop[idx]     = 1'b1;
          out_valid_d  = 1'b1;
          out_port_d   = PORT_IDX_W'(idx);
          out_data_d   = fifo_rd[idx];
          last_grant_d = PORT_IDX_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_port_q   <= '0;
      out_data_q   <= '0;
      last_grant_q <= PORT_IDX_W'(NUM_PORTS - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_port_q   <= out_port_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_port    = out_port_q;
  assign out_time_hi = out_data_q.hi;
  assign out_time_lo = out_data_q.lo;

`ifdef PTP_TSTAMP_DROP_CNT_EN
  logic [NUM_PORTS*CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (drop[p] && drop_cnt_q[p*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}})
          drop_cnt_q[p*CNT_WIDTH +: CNT_WIDTH] <= drop_cnt_q[p*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      end
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_ptp_tstamp_arbiter.sv
// Scoreboard bench for ptp_tstamp_arbiter: stimulus pushes expected entries, a negedge monitor pops and compares.
module tb_ptp_tstamp_arbiter;
  import ptp_tstamp_pkg::*;

  localparam int NP = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NP-1:0]   ts_valid = '0;
  logic [NP*32-1:0] ts_hi = '0;
  logic [NP*32-1:0] ts_lo = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2:0]      out_port;
  logic [31:0]     out_time_hi, out_time_lo;
  logic [NP-1:0]   drop;
`ifdef PTP_TSTAMP_DROP_CNT_EN
  logic [NP*CW-1:0] drop_cnt;
`endif

  ptp_tstamp_arbiter #(.NUM_PORTS(NP), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ts_valid    (ts_valid),
    .ts_hi       (ts_hi),
    .ts_lo       (ts_lo),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_port    (out_port),
    .out_time_hi (out_time_hi),
    .out_time_lo (out_time_lo),
`ifdef PTP_TSTAMP_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .drop        (drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  port;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   drop_seen[NP];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic put(input int p, input logic [31:0] hi, input logic [31:0] lo);
    ts_valid[p]       = 1'b1;
    ts_hi[32*p +: 32] = hi;
    ts_lo[32*p +: 32] = lo;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ts_valid = '0;
  endtask

  task automatic expect_out(input int p, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.port = 3'(p);
    e.hi   = hi;
    e.lo   = lo;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compares presented entries against the scoreboard and checks hold-while-stalled.
  initial begin
    exp_t e;
    exp_t held;
    logic stall_prev;
    stall_prev = 1'b0;
    held = '0;
    for (int p = 0; p < NP; p++) drop_seen[p] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        for (int p = 0; p < NP; p++) if (drop[p]) drop_seen[p]++;
        if (stall_prev) begin
          check("hold_port", 64'(out_port),    64'(held.port));
          check("hold_hi",   64'(out_time_hi), 64'(held.hi));
          check("hold_lo",   64'(out_time_lo), 64'(held.lo));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 64'(out_time_lo), 64'hDEAD_0000_0000_0000);
          end else begin
            e = sb.pop_front();
            check("out_port", 64'(out_port),    64'(e.port));
            check("out_hi",   64'(out_time_hi), 64'(e.hi));
            check("out_lo",   64'(out_time_lo), 64'(e.lo));
          end
        end
        stall_prev = out_valid && !out_ready;
        held.port  = out_port;
        held.hi    = out_time_hi;
        held.lo    = out_time_lo;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 64'(out_valid),   64'd0);
    check("rst_port",  64'(out_port),    64'd0);
    check("rst_hi",    64'(out_time_hi), 64'd0);
    check("rst_lo",    64'(out_time_lo), 64'd0);
    check("rst_drop",  64'(drop),        64'd0);
`ifdef PTP_TSTAMP_DROP_CNT_EN
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

    // Scenario 1: single strobe on port 2, two-cycle latency, hold after going empty
    out_ready = 1'b1;
    put(2, 32'h1, 32'h2);
    expect_out(2, 32'h1, 32'h2);
    step();
    check("s1_lat_n1", 64'(out_valid), 64'd0);
    step();
    check("s1_lat_n2", 64'(out_valid), 64'd1);
    step();
    check("s1_empty_valid", 64'(out_valid),   64'd0);
    check("s1_hold_hi",     64'(out_time_hi), 64'h1);
    check("s1_hold_lo",     64'(out_time_lo), 64'h2);

    // Scenario 2: all ports together, output in port order back-to-back
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < NP; p++) begin
      put(p, 32'h20 + 32'(p), 32'h30 + 32'(p));
      expect_out(p, 32'h20 + 32'(p), 32'h30 + 32'(p));
    end
    step();
    for (int k = 0; k < NP; k++) begin
      step();
      check("s2_seq", 64'({out_valid, out_port}), 64'({1'b1, 3'(k)}));
    end
    drain(10);

    // Scenario 3: output stalled, port 1 overflows on its fifth strobe
    do_reset();
    out_ready = 1'b0;
    put(0, 32'h40, 32'h41);
    expect_out(0, 32'h40, 32'h41);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      put(1, 32'h50 + 32'(k), 32'h60 + 32'(k));
      if (k < 4) expect_out(1, 32'h50 + 32'(k), 32'h60 + 32'(k));
      step();
    end
    check("s3_drop_pulse", 64'(drop), 64'b0010);
    step();
    check("s3_drop_clear", 64'(drop), 64'd0);
`ifdef PTP_TSTAMP_DROP_CNT_EN
    check("s3_drop_cnt1", 64'(drop_cnt[CW +: CW]), 64'd1);
    check("s3_drop_cnt0", 64'(drop_cnt[0 +: CW]),  64'd0);
`endif
    drain(20);

    // Scenario 4: out_ready 1,0,1 while valid
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(2, 32'h70 + 32'(2*k), 32'h71 + 32'(2*k));
      expect_out(2, 32'h70 + 32'(2*k), 32'h71 + 32'(2*k));
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("s4_stall_lo_a", 64'(out_time_lo), 64'h73);
    step();
    check("s4_stall_lo_b", 64'(out_time_lo), 64'h73);
    check("s4_stall_valid", 64'(out_valid), 64'd1);
    drain(20);

    // Scenario 5: ports 0 and 3 backlogged alternate
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(0, 32'h80 + 32'(k), 32'h90 + 32'(k));
      put(3, 32'hA0 + 32'(k), 32'hB0 + 32'(k));
      expect_out(0, 32'h80 + 32'(k), 32'h90 + 32'(k));
      expect_out(3, 32'hA0 + 32'(k), 32'hB0 + 32'(k));
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("s5_grant", 64'(out_port), (k % 2 == 1) ? 64'd3 : 64'd0);
      step();
    end
    drain(10);

    // Scenario 6: reset with entries queued and presented
    out_ready = 1'b0;
    put(1, 32'hC1, 32'hD1);
    put(2, 32'hC2, 32'hD2);
    put(3, 32'hC3, 32'hD3);
    step();
    step();
    check("s6_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    check("s6_flush_valid", 64'(out_valid), 64'd0);
    check("s6_flush_drop",  64'(drop),      64'd0);
`ifdef PTP_TSTAMP_DROP_CNT_EN
    check("s6_flush_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    step();
    check("s6_still_empty", 64'(out_valid), 64'd0);
    put(3, 32'hE3, 32'hF3);
    put(0, 32'hE0, 32'hF0);
    expect_out(0, 32'hE0, 32'hF0);
    expect_out(3, 32'hE3, 32'hF3);
    step();
    step();
    check("s6_first_grant", 64'({out_valid, out_port}), 64'({1'b1, 3'd0}));
    drain(10);

    step();
    check("drops_p0", 64'(drop_seen[0]), 64'd0);
    check("drops_p1", 64'(drop_seen[1]), 64'd1);
    check("drops_p2", 64'(drop_seen[2]), 64'd0);
    check("drops_p3", 64'(drop_seen[3]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
